// File: rtl/path_probe_pkg.sv
// Shared types and constants for the path launch/capture probe.
package path_probe_pkg;

  // Controller states. A run walks LAUNCH -> [WAIT] -> CAPTURE -> SETTLE
  // once per trial and closes through DONE back to IDLE.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LAUNCH  = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_SETTLE  = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  // Width of the programmable launch-to-capture delay.
  localparam int DELAY_W = 4;

  // Default width of the trial and mismatch counters.
  localparam int DEFAULT_TRIAL_W = 16;

  // Larger of two widths, used to size the shared timer.
  function automatic int max_w(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/probe_timer.sv
// Loadable down-counter shared by the WAIT and SETTLE phases.
// 'zero' is high in the cycle whose decrement empties the counter, so a
// phase loaded with N lasts exactly N cycles when the FSM leaves on 'zero'.
module probe_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  // Load takes priority; decrement stops at zero instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count <= CNT_W'(1));

endmodule

// File: rtl/path_probe_ctrl.sv
// Launch/capture controller for measuring a delay path in clock periods.
// Each trial toggles pathInput, samples pathResult captureDelay+1 periods
// later in a single raw flop, and counts samples that disagree with the
// settled value. Software sweeps captureDelay to find where errors vanish.
module path_probe_ctrl
  import path_probe_pkg::*;
#(
  parameter int INVERTING     = 0,
  parameter int SETTLE_CYCLES = 4,
  parameter int TRIAL_W       = DEFAULT_TRIAL_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [TRIAL_W-1:0] numTrials,
  input  logic [DELAY_W-1:0] captureDelay,
  output logic               pathInput,
  input  logic               pathResult,
  output logic               busy,
  output logic               done,
  output logic [TRIAL_W-1:0] errCount,
  output logic               lastSample
);

  localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
  localparam int TMR_W    = max_w(SETTLE_W, DELAY_W);

  localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES);
  localparam logic             INV_BIT     = (INVERTING != 0);

  state_t             state;
  logic [TRIAL_W-1:0] num_trials_q;
  logic [DELAY_W-1:0] capture_delay_q;
  logic [TRIAL_W-1:0] trial_cnt;
  logic               score_pending;

  logic               tmr_load;
  logic [TMR_W-1:0]   tmr_val;
  logic               tmr_dec;
  logic               tmr_zero;

  probe_timer #(
    .CNT_W (TMR_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  // Timer control: load the phase length on entry, count down while in it.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_dec  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        // An empty run still spends one settle beat, so its done pulse
        // arrives two cycles after start like the tail of a real run.
        if (start && (numTrials == '0)) begin
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(1);
        end
      end
      ST_LAUNCH: begin
        tmr_load = 1'b1;
        tmr_val  = TMR_W'(capture_delay_q);
      end
      ST_WAIT: begin
        tmr_dec = 1'b1;
      end
      ST_CAPTURE: begin
        tmr_load = 1'b1;
        tmr_val  = SETTLE_LOAD;
      end
      ST_SETTLE: begin
        tmr_dec = 1'b1;
      end
      default: begin
        tmr_load = 1'b0;
      end
    endcase
  end

  // Run sequencer with registered outputs, launch flop and capture flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      pathInput       <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      errCount        <= '0;
      lastSample      <= 1'b0;
      num_trials_q    <= '0;
      capture_delay_q <= '0;
      trial_cnt       <= '0;
      score_pending   <= 1'b0;
    end else begin
      done          <= 1'b0;
      score_pending <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            num_trials_q    <= numTrials;
            capture_delay_q <= captureDelay;
            errCount        <= '0;
            trial_cnt       <= '0;
            busy            <= 1'b1;
            state           <= (numTrials == '0) ? ST_SETTLE : ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          // Alternate edge direction every trial.
          pathInput <= ~pathInput;
          state     <= (capture_delay_q != '0) ? ST_WAIT : ST_CAPTURE;
        end
        ST_WAIT: begin
          if (tmr_zero) begin
            state <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          // The measurement element: one raw flop on an asynchronous input.
          // Scoring reads this flop next cycle so the count and lastSample
          // always agree, even if the sample was metastable.
          lastSample    <= pathResult;
          score_pending <= 1'b1;
          trial_cnt     <= trial_cnt + TRIAL_W'(1);
          state         <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (score_pending && (lastSample != (pathInput ^ INV_BIT)) &&
              (errCount != '1)) begin
            errCount <= errCount + TRIAL_W'(1);
          end
          if (tmr_zero) begin
            if (trial_cnt < num_trials_q) begin
              state <= ST_LAUNCH;
            end else begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_path_probe_ctrl.sv
// Bench for path_probe_ctrl: three instances against behavioural path models.
//   dut0: non-inverting, driving a pure 5-flop delay line
//   dut1: INVERTING=1, driving an inverter that settles within one period
//   dut2: TRIAL_W=3, driving a path that always disagrees with expectation
module tb_path_probe_ctrl;

  localparam int PATH_DEPTH = 5;
  localparam int SETTLE     = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   s_edge   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic        start0, pin0, pr0, busy0, done0, ls0;
  logic [15:0] ntr0, err0;
  logic [3:0]  cd0;
  logic        start1, pin1, pr1, busy1, done1, ls1;
  logic [15:0] ntr1, err1;
  logic [3:0]  cd1;
  logic        start2, pin2, pr2, busy2, done2, ls2;
  logic [2:0]  ntr2, err2;
  logic [3:0]  cd2;

  path_probe_ctrl #(.INVERTING(0), .SETTLE_CYCLES(SETTLE), .TRIAL_W(16)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .numTrials(ntr0), .captureDelay(cd0),
    .pathInput(pin0), .pathResult(pr0), .busy(busy0), .done(done0),
    .errCount(err0), .lastSample(ls0));

  path_probe_ctrl #(.INVERTING(1), .SETTLE_CYCLES(SETTLE), .TRIAL_W(16)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .numTrials(ntr1), .captureDelay(cd1),
    .pathInput(pin1), .pathResult(pr1), .busy(busy1), .done(done1),
    .errCount(err1), .lastSample(ls1));

  path_probe_ctrl #(.INVERTING(0), .SETTLE_CYCLES(SETTLE), .TRIAL_W(3)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .numTrials(ntr2), .captureDelay(cd2),
    .pathInput(pin2), .pathResult(pr2), .busy(busy2), .done(done2),
    .errCount(err2), .lastSample(ls2));

  // Path models
  logic [PATH_DEPTH-1:0] line0;
  always @(posedge clk) line0 <= {line0[PATH_DEPTH-2:0], pin0};
  assign pr0 = line0[PATH_DEPTH-1];
  assign pr1 = ~pin1;
  assign pr2 = ~pin2;

  // Activity monitors on dut0
  logic pin0_prev = 1'b0;
  int   tog0 = 0;
  int   dn0  = 0;
  always @(negedge clk) begin
    pin0_prev <= pin0;
    if (pin0 !== pin0_prev) tog0 <= tog0 + 1;
    if (done0 === 1'b1) dn0 <= dn0 + 1;
  end

  // Expected drive level of each instance, tracked from run history
  logic exp_pin0 = 1'b0;
  logic exp_pin1 = 1'b0;
  logic exp_pin2 = 1'b0;

  task automatic kick(input int which, input int n, input int d);
    @(negedge clk);
    case (which)
      0: begin start0 = 1'b1; ntr0 = 16'(n); cd0 = 4'(d); end
      1: begin start1 = 1'b1; ntr1 = 16'(n); cd1 = 4'(d); end
      default: begin start2 = 1'b1; ntr2 = 3'(n); cd2 = 4'(d); end
    endcase
    @(posedge clk);
    #1;
    s_edge = cyc;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
  endtask

  // Returns done position as offset from start edge (1 = first cycle after it).
  task automatic wait_done(input int which, input int budget, output int off, output bit to);
    logic dv;
    to  = 1'b1;
    off = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      dv = (which == 0) ? done0 : ((which == 1) ? done1 : done2);
      if (dv === 1'b1) begin
        off = cyc - s_edge + 1;
        to  = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({pin0, busy0, done0, ls0, err0} !== 20'd0) begin
      failures++; $display("FAIL reset_dut0: got %b required 0", {pin0, busy0, done0, ls0, err0});
    end
    checks++;
    if ({pin1, busy1, done1, ls1, err1} !== 20'd0) begin
      failures++; $display("FAIL reset_dut1: got %b required 0", {pin1, busy1, done1, ls1, err1});
    end
    checks++;
    if ({pin2, busy2, done2, ls2, err2} !== 7'd0) begin
      failures++; $display("FAIL reset_dut2: got %b required 0", {pin2, busy2, done2, ls2, err2});
    end
    rst = 1'b0;
    repeat (8) @(posedge clk);
  endtask

  task automatic test_match_run();
    int off; bit to; int t0; int d0;
    @(posedge clk); t0 = tog0; d0 = dn0;
    kick(0, 8, 6);
    wait_done(0, 150, off, to);
    checks++; if (to) begin failures++; $display("FAIL match_timeout: no done within budget"); end
    checks++;
    if (off != 1 + 8 * (6 + 2 + SETTLE)) begin
      failures++; $display("FAIL match_done_cycle: got %0d required %0d", off, 1 + 8 * (6 + 2 + SETTLE));
    end
    checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL match_busy_at_done: got %b required 0", busy0); end
    checks++; if (err0 !== 16'd0) begin failures++; $display("FAIL match_err: got %0d required 0", err0); end
    repeat (3) @(posedge clk);
    checks++; if (tog0 - t0 != 8) begin failures++; $display("FAIL match_toggles: got %0d required 8", tog0 - t0); end
    checks++; if (dn0 - d0 != 1) begin failures++; $display("FAIL match_done_pulses: got %0d required 1", dn0 - d0); end
    checks++; if (pin0 !== exp_pin0) begin failures++; $display("FAIL match_pin: got %b required %b", pin0, exp_pin0); end
    checks++; if (ls0 !== exp_pin0) begin failures++; $display("FAIL match_last: got %b required %b", ls0, exp_pin0); end
  endtask

  task automatic test_early_capture();
    int off; bit to;
    kick(0, 8, 2);
    wait_done(0, 120, off, to);
    checks++; if (to) begin failures++; $display("FAIL early_timeout: no done within budget"); end
    checks++; if (off != 1 + 8 * (2 + 2 + SETTLE)) begin failures++; $display("FAIL early_done_cycle: got %0d required %0d", off, 1 + 8 * (2 + 2 + SETTLE)); end
    checks++; if (err0 !== 16'd8) begin failures++; $display("FAIL early_err: got %0d required 8", err0); end
    checks++; if (ls0 !== ~exp_pin0) begin failures++; $display("FAIL early_last: got %b required %b", ls0, ~exp_pin0); end
    repeat (8) @(posedge clk);
  endtask

  task automatic test_zero_trials();
    kick(0, 0, int'($urandom_range(0, 15)));
    @(negedge clk);
    checks++;
    if (busy0 !== 1'b1 || done0 !== 1'b0) begin
      failures++; $display("FAIL zero_s1: got busy=%b done=%b required busy=1 done=0", busy0, done0);
    end
    @(negedge clk);
    checks++; if (done0 !== 1'b1) begin failures++; $display("FAIL zero_done_s2: got %b required 1", done0); end
    checks++; if (err0 !== 16'd0) begin failures++; $display("FAIL zero_err: got %0d required 0", err0); end
    checks++; if (pin0 !== exp_pin0) begin failures++; $display("FAIL zero_pin: got %b required %b", pin0, exp_pin0); end
    repeat (8) @(posedge clk);
  endtask

  task automatic test_inverting();
    int off; bit to; int n; int d;
    for (int r = 0; r < 3; r++) begin
      n = (r == 0) ? 4 : int'($urandom_range(1, 5));
      d = (r == 0) ? 0 : int'($urandom_range(0, 15));
      kick(1, n, d);
      wait_done(1, 130, off, to);
      exp_pin1 = exp_pin1 ^ n[0];
      checks++; if (to || off != 1 + n * (d + 2 + SETTLE)) begin failures++; $display("FAIL inv_done_cycle run%0d: got %0d required %0d", r, off, 1 + n * (d + 2 + SETTLE)); end
      checks++; if (err1 !== 16'd0) begin failures++; $display("FAIL inv_err run%0d: got %0d required 0", r, err1); end
      checks++; if (pin1 !== exp_pin1 || ls1 !== ~exp_pin1) begin failures++; $display("FAIL inv_pin_last run%0d: got %b%b required %b%b", r, pin1, ls1, exp_pin1, ~exp_pin1); end
      repeat (4) @(posedge clk);
    end
  endtask

  task automatic test_saturation();
    int off; bit to;
    kick(2, 7, 0);
    wait_done(2, 80, off, to);
    exp_pin2 = ~exp_pin2;
    checks++; if (to || off != 1 + 7 * (0 + 2 + SETTLE)) begin failures++; $display("FAIL sat1_done_cycle: got %0d required %0d", off, 1 + 7 * (2 + SETTLE)); end
    checks++; if (err2 !== 3'd7) begin failures++; $display("FAIL sat1_err: got %0d required 7", err2); end
    checks++; if (ls2 !== ~exp_pin2) begin failures++; $display("FAIL sat1_last: got %b required %b", ls2, ~exp_pin2); end
    repeat (4) @(posedge clk);
    kick(2, 7, 3);
    @(negedge clk);
    checks++; if (err2 !== 3'd0) begin failures++; $display("FAIL sat2_cleared: got %0d required 0", err2); end
    wait_done(2, 100, off, to);
    exp_pin2 = ~exp_pin2;
    checks++; if (to || off != 1 + 7 * (3 + 2 + SETTLE)) begin failures++; $display("FAIL sat2_done_cycle: got %0d required %0d", off, 1 + 7 * (3 + 2 + SETTLE)); end
    checks++; if (err2 !== 3'd7) begin failures++; $display("FAIL sat2_err: got %0d required 7", err2); end
    repeat (4) @(posedge clk);
  endtask

  task automatic test_reset_midrun();
    int d0;
    kick(0, 3, 2);
    // Trial period is 8, so offset 10 is the first WAIT cycle of trial two.
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cyc - s_edge + 1 == 10) break;
    end
    checks++;
    if (err0 !== 16'd1 || busy0 !== 1'b1) begin
      failures++; $display("FAIL midrun_pre: got err=%0d busy=%b required err=1 busy=1", err0, busy0);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({pin0, busy0, done0, ls0, err0} !== 20'd0) begin
      failures++; $display("FAIL midrun_reset: got %b required 0", {pin0, busy0, done0, ls0, err0});
    end
    rst = 1'b0;
    exp_pin0 = 1'b0; exp_pin1 = 1'b0; exp_pin2 = 1'b0;
    @(posedge clk); d0 = dn0;
    repeat (40) @(posedge clk);
    checks++; if (dn0 - d0 != 0) begin failures++; $display("FAIL midrun_no_done: got %0d pulses required 0", dn0 - d0); end
    checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL midrun_idle: got busy=%b required 0", busy0); end
  endtask

  task automatic test_start_ignored();
    int off; bit to; int t0;
    @(posedge clk); t0 = tog0;
    kick(0, 3, 1);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 4) begin start0 = 1'b1; ntr0 = 16'd7; cd0 = 4'd9; end
      if (c == 5) start0 = 1'b0;
    end
    wait_done(0, 60, off, to);
    exp_pin0 = ~exp_pin0;
    checks++; if (to || off != 1 + 3 * (1 + 2 + SETTLE)) begin failures++; $display("FAIL ignore_done_cycle: got %0d required %0d", off, 1 + 3 * (1 + 2 + SETTLE)); end
    checks++; if (err0 !== 16'd3) begin failures++; $display("FAIL ignore_err: got %0d required 3", err0); end
    repeat (10) @(posedge clk);
    checks++; if (tog0 - t0 != 3) begin failures++; $display("FAIL ignore_toggles: got %0d required 3", tog0 - t0); end
    checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL ignore_no_restart: got busy=%b required 0", busy0); end
  endtask

  task automatic test_random();
    int off; bit to; int n; int d; int exp_err; logic exp_ls;
    for (int r = 0; r < 6; r++) begin
      n = int'($urandom_range(1, 5));
      d = int'($urandom_range(0, 15));
      // The delay line shows a new level PATH_DEPTH+1 periods after launch;
      // a window of d+1 periods catches it only if it is longer than PATH_DEPTH.
      exp_err  = (d + 1 > PATH_DEPTH) ? 0 : n;
      exp_pin0 = exp_pin0 ^ n[0];
      exp_ls   = (exp_err == 0) ? exp_pin0 : ~exp_pin0;
      kick(0, n, d);
      wait_done(0, 130, off, to);
      checks++; if (to || off != 1 + n * (d + 2 + SETTLE)) begin failures++; $display("FAIL rand_done_cycle n=%0d d=%0d: got %0d required %0d", n, d, off, 1 + n * (d + 2 + SETTLE)); end
      checks++; if (err0 !== 16'(exp_err)) begin failures++; $display("FAIL rand_err n=%0d d=%0d: got %0d required %0d", n, d, err0, exp_err); end
      checks++; if (pin0 !== exp_pin0) begin failures++; $display("FAIL rand_pin n=%0d d=%0d: got %b required %b", n, d, pin0, exp_pin0); end
      checks++; if (ls0 !== exp_ls) begin failures++; $display("FAIL rand_last n=%0d d=%0d: got %b required %b", n, d, ls0, exp_ls); end
      repeat (8) @(posedge clk);
    end
  endtask

  initial begin
    rst = 1'b1;
    start0 = 1'b0; ntr0 = '0; cd0 = '0;
    start1 = 1'b0; ntr1 = '0; cd1 = '0;
    start2 = 1'b0; ntr2 = '0; cd2 = '0;
    test_reset();
    test_match_run();
    test_early_capture();
    test_zero_trials();
    test_inverting();
    test_saturation();
    test_reset_midrun();
    test_start_ignored();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
